// File: rtl/traffic_pkg.sv
// Shared intersection definitions: side-light encoding and the request FSM state type.
package traffic_pkg;

  localparam logic [1:0] LIGHT_OFF = 2'd0;
  localparam logic [1:0] LIGHT_RED = 2'd1;
  localparam logic [1:0] LIGHT_YEL = 2'd2;
  localparam logic [1:0] LIGHT_GRN = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SERVING = 2'd2
  } req_state_t;

endpackage

// File: rtl/side_sensor_conditioner_if.sv
// Detector/controller signal bundle for the side-street sensor conditioner.
interface side_sensor_conditioner_if #(
  parameter int unsigned WAIT_W = 4
);

  logic              sensor_raw;
  logic [1:0]        side_light;
  logic              sensor;
  logic              present;
  logic [WAIT_W-1:0] wait_cnt;
  logic              starve;

  modport master (
    output sensor_raw,
    output side_light,
    input  sensor,
    input  present,
    input  wait_cnt,
    input  starve
  );

  modport slave (
    input  sensor_raw,
    input  side_light,
    output sensor,
    output present,
    output wait_cnt,
    output starve
  );

endinterface

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser plus debounce: present follows the detector only after
// DEB_CYCLES consecutive differing synchronised samples.
module sensor_debounce #(
  parameter int unsigned DEB_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_raw,
  output logic present
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [1:0]       sync_q;
  logic             s_sync;
  logic [CNT_W-1:0] cnt_q;

  assign s_sync = sync_q[1];

  // Counter only runs while the synchronised level disagrees with present.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= 2'b00;
      cnt_q   <= '0;
      present <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], sensor_raw};
      if (s_sync == present) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        present <= s_sync;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/side_sensor_conditioner.sv
// Turns the debounced side-street detector into a latched service request with
// wait tracking and starvation flag. Optional SENSOR_HOLDOFF_EN adds a
// post-service holdoff that defers re-arming to give the main road a minimum green.
module side_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 3,
  parameter int unsigned WAIT_W     = 4,
  parameter int unsigned MAX_WAIT   = 15
`ifdef SENSOR_HOLDOFF_EN
  ,
  parameter int unsigned HOLDOFF    = 6
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  side_sensor_conditioner_if.slave bus
);

  logic              present;
  logic              present_d;
  logic              green_d;
  logic              is_green;
  logic              present_rise;
  req_state_t        state_q;
  req_state_t        state_next;
  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_next;
  logic              sensor_q;
  logic              starve_q;

`ifdef SENSOR_HOLDOFF_EN
  localparam int unsigned HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_next;
  logic              rearm_q;
  logic              rearm_next;
`endif

  sensor_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_debounce (
    .clk        (clk),
    .reset      (reset),
    .sensor_raw (bus.sensor_raw),
    .present    (present)
  );

  assign is_green     = (bus.side_light == LIGHT_GRN);
  assign present_rise = present & ~present_d;

  // State, edge-detect copies and registered output decodes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      present_d <= 1'b0;
      green_d   <= 1'b0;
      sensor_q  <= 1'b0;
      starve_q  <= 1'b0;
`ifdef SENSOR_HOLDOFF_EN
      hold_q    <= '0;
      rearm_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_next;
      wait_q    <= wait_next;
      present_d <= present;
      green_d   <= is_green;
      sensor_q  <= (state_next == PENDING);
      starve_q  <= (state_next == PENDING) && (wait_next == WAIT_W'(MAX_WAIT));
`ifdef SENSOR_HOLDOFF_EN
      hold_q    <= hold_next;
      rearm_q   <= rearm_next;
`endif
    end
  end

  // Request FSM next-state and wait counter.
  always_comb begin
    state_next = state_q;
    wait_next  = wait_q;
`ifdef SENSOR_HOLDOFF_EN
    hold_next  = (hold_q != '0) ? hold_q - HOLD_W'(1) : '0;
    rearm_next = rearm_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef SENSOR_HOLDOFF_EN
        if (present_rise && is_green) begin
          state_next = SERVING;
          rearm_next = 1'b0;
        end else if (present_rise || rearm_q) begin
          // Park in IDLE until the holdoff drains; hold_q==1 drains on this edge.
          if (hold_q > HOLD_W'(1)) begin
            rearm_next = 1'b1;
          end else begin
            state_next = PENDING;
            rearm_next = 1'b0;
          end
        end
`else
        if (present_rise) begin
          state_next = is_green ? SERVING : PENDING;
        end
`endif
      end
      PENDING: begin
        if (is_green) begin
          state_next = SERVING;
          wait_next  = '0;
        end else if (wait_q != WAIT_W'(MAX_WAIT)) begin
          wait_next = wait_q + WAIT_W'(1);
        end
      end
      SERVING: begin
        wait_next = '0;
        if (green_d && !is_green) begin
`ifdef SENSOR_HOLDOFF_EN
          hold_next  = HOLD_W'(HOLDOFF);
          rearm_next = present;
          state_next = IDLE;
`else
          state_next = present ? PENDING : IDLE;
`endif
        end
      end
      default: begin
        state_next = IDLE;
        wait_next  = '0;
      end
    endcase
  end

  assign bus.sensor   = sensor_q;
  assign bus.present  = present;
  assign bus.wait_cnt = wait_q;
  assign bus.starve   = starve_q;

endmodule

// File: tb/tb_side_sensor_conditioner.sv
// Directed bench for side_sensor_conditioner with a per-cycle expectation queue.
module tb_side_sensor_conditioner;
  import traffic_pkg::*;

  typedef struct {
    string      tag;
    logic       sensor;
    logic       present;
    logic [3:0] wait_cnt;
    logic       starve;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  exp_t exp_q[$];

  side_sensor_conditioner_if #(.WAIT_W(4)) bus ();

  side_sensor_conditioner #(
    .DEB_CYCLES (3),
    .WAIT_W     (4),
    .MAX_WAIT   (15)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_out(input string tag, input logic s, input logic p,
                            input logic [3:0] w, input logic st);
    exp_t e;
    e.tag      = tag;
    e.sensor   = s;
    e.present  = p;
    e.wait_cnt = w;
    e.starve   = st;
    exp_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    total++;
    assert (exp_q.size() != 0) else begin
      bad++;
      $error("FAIL scoreboard_empty got=0 entries exp=1");
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++;
      assert (bus.sensor === e.sensor) else begin
        bad++;
        $error("FAIL %s sensor got=%0b exp=%0b t=%0t", e.tag, bus.sensor, e.sensor, $time);
      end
      total++;
      assert (bus.present === e.present) else begin
        bad++;
        $error("FAIL %s present got=%0b exp=%0b t=%0t", e.tag, bus.present, e.present, $time);
      end
      total++;
      assert (bus.wait_cnt === e.wait_cnt) else begin
        bad++;
        $error("FAIL %s wait_cnt got=%0d exp=%0d t=%0t", e.tag, bus.wait_cnt, e.wait_cnt, $time);
      end
      total++;
      assert (bus.starve === e.starve) else begin
        bad++;
        $error("FAIL %s starve got=%0b exp=%0b t=%0t", e.tag, bus.starve, e.starve, $time);
      end
    end
  endtask

  // Drive inputs for one cycle, queue the expected post-edge outputs, then check.
  task automatic step(input logic raw, input logic [1:0] light, input string tag,
                      input logic s, input logic p, input logic [3:0] w, input logic st);
    bus.sensor_raw = raw;
    bus.side_light = light;
    expect_out(tag, s, p, w, st);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    reset          = 1'b0;
    bus.sensor_raw = 1'b0;
    bus.side_light = LIGHT_OFF;

    #12;
    expect_out("reset", 1'b0, 1'b0, 4'd0, 1'b0);
    check_out();
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Clean press on red: present at cycle 5, sensor at 6, then wait counts up.
    for (int i = 0; i < 4; i++) step(1'b1, LIGHT_RED, "press_sync", 1'b0, 1'b0, 4'd0, 1'b0);
    step(1'b1, LIGHT_RED, "press_present", 1'b0, 1'b1, 4'd0, 1'b0);
    step(1'b1, LIGHT_RED, "press_sensor", 1'b1, 1'b1, 4'd0, 1'b0);
    for (int k = 1; k <= 7; k++) step(1'b1, LIGHT_RED, "press_wait", 1'b1, 1'b1, 4'(k), 1'b0);

    // Service at wait_cnt=7; vehicle leaves during green, so exit returns to IDLE.
    step(1'b0, LIGHT_GRN, "serve", 1'b0, 1'b1, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, LIGHT_GRN, "serve_hold", 1'b0, 1'b1, 4'd0, 1'b0);
    step(1'b0, LIGHT_GRN, "serve_gone", 1'b0, 1'b0, 4'd0, 1'b0);
    step(1'b0, LIGHT_GRN, "serve_gone2", 1'b0, 1'b0, 4'd0, 1'b0);
    step(1'b0, LIGHT_YEL, "exit_idle", 1'b0, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, LIGHT_RED, "idle_quiet", 1'b0, 1'b0, 4'd0, 1'b0);

    // Two-cycle glitch must be rejected.
    for (int i = 0; i < 2; i++) step(1'b1, LIGHT_RED, "glitch_hi", 1'b0, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, LIGHT_RED, "glitch_lo", 1'b0, 1'b0, 4'd0, 1'b0);

    // Re-arm: vehicle still present when side green ends.
    for (int i = 0; i < 4; i++) step(1'b1, LIGHT_RED, "rearm_sync", 1'b0, 1'b0, 4'd0, 1'b0);
    step(1'b1, LIGHT_RED, "rearm_present", 1'b0, 1'b1, 4'd0, 1'b0);
    step(1'b1, LIGHT_RED, "rearm_sensor", 1'b1, 1'b1, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, LIGHT_GRN, "rearm_green", 1'b0, 1'b1, 4'd0, 1'b0);
    step(1'b1, LIGHT_YEL, "rearm_exit", 1'b1, 1'b1, 4'd0, 1'b0);

    // Starvation: wait saturates at 15 with starve high from that cycle.
    for (int k = 1; k <= 20; k++) begin
      logic [3:0] w;
      w = (k >= 15) ? 4'd15 : 4'(k);
      step(1'b1, LIGHT_RED, "starve", 1'b1, 1'b1, w, (k >= 15));
    end

    // Asynchronous reset mid-wait, then present rebuilds over the full latency.
    reset = 1'b0;
    #2;
    expect_out("async_reset", 1'b0, 1'b0, 4'd0, 1'b0);
    check_out();
    #2;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, LIGHT_RED, "post_rst_sync", 1'b0, 1'b0, 4'd0, 1'b0);
    step(1'b1, LIGHT_RED, "post_rst_present", 1'b0, 1'b1, 4'd0, 1'b0);
    step(1'b1, LIGHT_RED, "post_rst_sensor", 1'b1, 1'b1, 4'd0, 1'b0);
    step(1'b1, LIGHT_RED, "post_rst_wait", 1'b1, 1'b1, 4'd1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/side_sensor_conditioner.md
Name: side_sensor_conditioner

Overview:
Conditions the raw side-street vehicle detector into the clean, latched `sensor` request consumed by the intersection light controller. It synchronises and debounces the detector, holds a request until the side road is actually served (side light green), and re-arms if a vehicle is still waiting when side green ends. It also tracks how long a request has waited and flags starvation.

Parameters:
DEB_CYCLES, 3, consecutive stable synchronised samples required to change the debounced level (>=1)
WAIT_W, 4, width of wait counter
MAX_WAIT, 15, wait count at which starve asserts; saturation value (<= 2**WAIT_W-1)
HOLDOFF, 6, post-service holdoff cycles (used only with SENSOR_HOLDOFF_EN)

Ports:
clk  input  1  system clock; all logic rising-edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
sensor_raw  input  1  raw detector, asynchronous to clk, may bounce
side_light  input  2  current side light from controller: 0 off, 1 red, 2 yellow, 3 green
sensor  output  1  latched service request to controller's sensor input
present  output  1  debounced vehicle presence
wait_cnt  output  WAIT_W  cycles the current request has been pending, saturating
starve  output  1  high while pending and wait_cnt == MAX_WAIT

Behaviour:
- Reset (reset==0, async): sync flops 0, debounce counter 0, present 0, FSM IDLE, sensor 0, wait_cnt 0, starve 0, holdoff counter 0.
- Sync: 2-flop synchroniser on sensor_raw -> s_sync. 2-cycle latency.
- Debounce: counter clears whenever s_sync == present. While s_sync != present it increments; when it reaches DEB_CYCLES, present <= s_sync and counter clears. Raw-edge-to-present latency = 2 + DEB_CYCLES cycles. Any glitch shorter than DEB_CYCLES samples is rejected.
- Registered copies of present (present_d) and of side_light==3 (green_d) are kept for edge detection.
- FSM states IDLE, PENDING, SERVING:
  - IDLE: on present rising (present & ~present_d) and side_light != 3 -> PENDING. If side_light == 3 at that edge -> SERVING (already being served, no request raised).
  - PENDING: sensor=1; wait_cnt increments each cycle, saturating at MAX_WAIT. When side_light == 3 -> SERVING, wait_cnt <= 0 on the same edge.
  - SERVING: sensor=0, wait_cnt=0. On side_light leaving green (green_d & side_light != 3): if present==1 -> PENDING (re-arm for remaining traffic), else -> IDLE.
- present falling while PENDING: the request stays latched. A vehicle that left is still served once, by design.
- side_light == 0 (off/reset) is treated as non-green.
- sensor is a registered FSM decode, glitch-free. It asserts 1 cycle after entering PENDING and drops 1 cycle after side green is seen.
- starve = (state==PENDING) && (wait_cnt==MAX_WAIT). It clears together with wait_cnt.
- Reset mid-request: everything returns to reset values immediately. present rebuilds only after the full 2+DEB_CYCLES latency.

Optional Feature:
SENSOR_HOLDOFF_EN. When defined, the SERVING-exit transition loads a holdoff counter with HOLDOFF and goes to IDLE or PENDING as above. However, the IDLE->PENDING or SERVING->PENDING entry is deferred while holdoff != 0: the FSM waits in IDLE with an internal re-arm flag, and the counter decrements each cycle. This gives the main road a minimum green. wait_cnt does not count during holdoff. When undefined: no holdoff counter, and transitions are immediate as specified.

Decomposition:
- Shared package traffic_pkg: light encoding constants LIGHT_OFF=2'd0, LIGHT_RED=2'd1, LIGHT_YEL=2'd2, LIGHT_GRN=2'd3; enum typedef req_state_t {IDLE, PENDING, SERVING}.
- One sub-module, sensor_debounce: synchroniser plus debounce counter, parameter DEB_CYCLES, output present.

Test Plan:
- Clean press: sensor_raw 0->1 held, side_light=1. Required: present at cycle 5 and sensor at cycle 6; wait_cnt counts 1,2,3...
- Glitch: sensor_raw high for 2 cycles, DEB_CYCLES=3. Required: present stays 0 and sensor stays 0.
- Service: PENDING with wait_cnt=7, then side_light=3. Required: next cycle sensor=0 and wait_cnt=0; with side_light 3->2 and present=0, required: IDLE and sensor stays 0.
- Re-arm: present held 1 through side green, then side_light 3->2. Required: sensor=1 one cycle later.
- Starvation: pending 20 cycles with side_light=1. Required: wait_cnt saturates at 15 and starve=1 from that cycle. reset pulsed low mid-wait -> all outputs 0 asynchronously.
- With SENSOR_HOLDOFF_EN, HOLDOFF=6: present=1 at green exit. Required: sensor rises 7 cycles after side_light leaves 3, not 1.
